// File: rtl/grid_id_probe.sv
// grid_id_probe: Avalon-MM master that reads the 4-word ID window of the grid
// close-ID slave and checks it against a fixed signature. Results are exposed
// through a small CSR slave and the sticky coe_id_ok sideband flag.
module grid_id_probe #(
    parameter logic [31:0] SIG_A      = 32'hA5A5A5A5,
    parameter logic [31:0] SIG_B      = 32'h5A5A5A5A,
    parameter int unsigned TIMEOUT    = 255,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset,

    output logic [1:0]  avm_Probe_address,
    output logic        avm_Probe_read,
    input  logic [31:0] avm_Probe_readdata,
    input  logic        avm_Probe_waitrequest,

    input  logic [1:0]  avs_Ctrl_address,
    input  logic        avs_Ctrl_read,
    input  logic        avs_Ctrl_write,
    input  logic [31:0] avs_Ctrl_writedata,
    output logic [31:0] avs_Ctrl_readdata,
    output logic        avs_Ctrl_waitrequest,

    output logic        coe_id_ok
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        CHECK = 2'd2
    } probeState_e;

    // The abort fires on the stall edge where the counter has already seen
    // TIMEOUT-1 stalled cycles, so exactly TIMEOUT stalled cycles are allowed.
    localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT - 1);

    probeState_e state;
    probeState_e nextState;

    logic [1:0]  idx;
    logic [7:0]  stallCnt;
    logic [31:0] cap [4];
    logic [15:0] passCnt;
    logic [15:0] failCnt;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeoutFlag;
    logic        idOk;
    logic        autoPending;

    logic        startReq;
    logic        startNow;
    logic        xferDone;
    logic        stallCycle;
    logic        stallHit;
    logic        match;

    logic        unusedCtrlBits;

    // The CSR read strobe is not needed because readdata is a pure address decode.
    assign unusedCtrlBits = &{1'b0, avs_Ctrl_read, avs_Ctrl_writedata[31:1]};

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [15:0] satInc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    // Decode of start requests, transfer completion, stall and signature match.
    always_comb begin
        startReq   = avs_Ctrl_write && (avs_Ctrl_address == 2'd0) && avs_Ctrl_writedata[0];
        startNow   = (state == IDLE) && (startReq || autoPending);
        xferDone   = (state == READ) && !avm_Probe_waitrequest;
        stallCycle = (state == READ) && avm_Probe_waitrequest;
        stallHit   = stallCycle && (stallCnt == STALL_LIMIT);
        match      = (cap[0] == 32'd0) && (cap[1] == SIG_A) &&
                     (cap[2] == 32'd0) && (cap[3] == SIG_B);
    end

    // State register; reset drops the probe immediately without waiting for the slave.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: a start outside IDLE is simply not seen, so it cannot queue.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (startNow) begin
                    nextState = READ;
                end
            end
            READ: begin
                if (stallHit) begin
                    nextState = IDLE;
                end else if (xferDone && (idx == 2'd3)) begin
                    nextState = CHECK;
                end
            end
            CHECK: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Master outputs: read only in READ, address follows idx which only moves on completion.
    always_comb begin
        avm_Probe_read    = (state == READ);
        avm_Probe_address = idx;
    end

    // Probe datapath: word index, stall counter, captured words, status and counters.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            idx         <= 2'd0;
            stallCnt    <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                cap[i] <= 32'd0;
            end
            passCnt     <= 16'd0;
            failCnt     <= 16'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeoutFlag <= 1'b0;
            idOk        <= 1'b0;
            autoPending <= AUTO_START;
        end else begin
            autoPending <= 1'b0;
            if (startNow) begin
                idx         <= 2'd0;
                stallCnt    <= 8'd0;
                busy        <= 1'b1;
                done        <= 1'b0;
                pass        <= 1'b0;
                timeoutFlag <= 1'b0;
            end else if (xferDone) begin
                cap[idx] <= avm_Probe_readdata;
                stallCnt <= 8'd0;
                if (idx != 2'd3) begin
                    idx <= idx + 2'd1;
                end
            end else if (stallHit) begin
                idx         <= 2'd0;
                stallCnt    <= 8'd0;
                timeoutFlag <= 1'b1;
                done        <= 1'b1;
                pass        <= 1'b0;
                idOk        <= 1'b0;
                busy        <= 1'b0;
                failCnt     <= satInc(failCnt);
            end else if (stallCycle) begin
                stallCnt <= stallCnt + 8'd1;
            end else if (state == CHECK) begin
                idx  <= 2'd0;
                pass <= match;
                idOk <= match;
                done <= 1'b1;
                busy <= 1'b0;
                if (match) begin
                    passCnt <= satInc(passCnt);
                end else begin
                    failCnt <= satInc(failCnt);
                end
            end
        end
    end

    // CSR read mux is a pure function of the address; the slave never stalls.
    always_comb begin
        avs_Ctrl_readdata    = 32'd0;
        avs_Ctrl_waitrequest = 1'b0;
        unique case (avs_Ctrl_address)
            2'd0: avs_Ctrl_readdata = {28'd0, timeoutFlag, pass, done, busy};
            2'd1: avs_Ctrl_readdata = cap[1];
            2'd2: avs_Ctrl_readdata = cap[3];
            2'd3: avs_Ctrl_readdata = {failCnt, passCnt};
            default: avs_Ctrl_readdata = 32'd0;
        endcase
    end

    assign coe_id_ok = idOk;

endmodule
